// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the reaction-game round sequencer
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PLAY,
        ST_GAP,
        ST_OVER
    } state_e;

    localparam int TGT_W   = 4;
    localparam int SCORE_W = 8;

    // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_POLY = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Galois LFSR used to pick round targets
//
// Ports:
//   clock  - system clock
//   resetn - asynchronous active-low reset, loads SEED
//   q      - current LFSR state, advances every cycle
module lfsr8
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       resetn,
    output logic [7:0] q
);

    // The polynomial has a constant term, so a nonzero state never maps to zero
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= SEED;
        end else if (q[0]) begin
            q <= (q >> 1) ^ LFSR_POLY;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/round_master.sv
// rtl/round_master.sv - round sequencer: target pick, response window, score and lives
//
// Ports:
//   clock, resetn  - system clock, asynchronous active-low reset
//   start          - level; starts a game from IDLE or OVER
//   correct        - registered hit verdict from the button checker
//   randomnumber   - one-hot target, zero outside PLAY
//   timerdone      - high outside PLAY, blanks the checker
//   score, lives   - hits this game (saturating) and remaining lives
//   round_active   - high in PLAY
//   game_over      - high in OVER
module round_master
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ROUND_TICKS = 20,
    parameter int unsigned MIN_TICKS   = 4,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned LIVES       = 3,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               correct,
    output logic [TGT_W-1:0]   randomnumber,
    output logic               timerdone,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               round_active,
    output logic               game_over
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_W = $clog2(ROUND_TICKS + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TICK_W-1:0] WIN_INIT = TICK_W'(ROUND_TICKS);
    localparam logic [TICK_W-1:0] WIN_MIN  = TICK_W'(MIN_TICKS);

    state_e               state_q;
    logic [PRE_W-1:0]     pre_q;
    logic [TICK_W-1:0]    tick_q;
    logic [TICK_W-1:0]    window_q;
    logic [GAP_W-1:0]     gap_q;
    logic [TGT_W-1:0]     target_q;
    logic [TGT_W-1:0]     rnum_q;
    logic                 timerdone_q;
    logic [SCORE_W-1:0]   score_q;
    logic [1:0]           lives_q;
    logic                 active_q;
    logic                 over_q;

    logic [7:0]           lfsr_q;
    logic                 lfsr_unused;

    logic [TGT_W-1:0]     cand;
    logic [TGT_W-1:0]     target_d;
    logic                 tick_wrap;
    logic                 expired;
    logic [TICK_W-1:0]    window_d;
    logic [SCORE_W-1:0]   score_d;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[7:2];

    // Rotating away from the previous target keeps a held button from
    // scoring the next round.
    assign cand     = TGT_W'(1) << lfsr_q[1:0];
    assign target_d = (cand == target_q) ? {cand[TGT_W-2:0], cand[TGT_W-1]} : cand;

    // Expiry is the last prescaler cycle of the last tick of the window,
    // so PLAY lasts exactly window * TICK_DIV cycles.
    assign tick_wrap = (pre_q == PRE_LAST);
    assign expired   = tick_wrap && (tick_q == window_q - TICK_W'(1));

    assign window_d = (window_q > WIN_MIN) ? window_q - TICK_W'(1) : WIN_MIN;
    assign score_d  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            tick_q      <= '0;
            window_q    <= WIN_INIT;
            gap_q       <= '0;
            target_q    <= '0;
            rnum_q      <= '0;
            timerdone_q <= 1'b1;
            score_q     <= '0;
            lives_q     <= 2'(LIVES);
            active_q    <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        score_q  <= '0;
                        lives_q  <= 2'(LIVES);
                        window_q <= WIN_INIT;
                        over_q   <= 1'b0;
                        state_q  <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    target_q    <= target_d;
                    rnum_q      <= target_d;
                    timerdone_q <= 1'b0;
                    active_q    <= 1'b1;
                    pre_q       <= '0;
                    tick_q      <= '0;
                    state_q     <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (correct) begin
                        // A hit on the expiry cycle still wins
                        score_q     <= score_d;
                        window_q    <= window_d;
                        rnum_q      <= '0;
                        timerdone_q <= 1'b1;
                        active_q    <= 1'b0;
                        gap_q       <= '0;
                        state_q     <= ST_GAP;
                    end else if (expired) begin
                        lives_q     <= lives_q - 2'd1;
                        rnum_q      <= '0;
                        timerdone_q <= 1'b1;
                        active_q    <= 1'b0;
                        gap_q       <= '0;
                        if (lives_q == 2'd1) begin
                            over_q  <= 1'b1;
                            state_q <= ST_OVER;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else if (tick_wrap) begin
                        pre_q  <= '0;
                        tick_q <= tick_q + TICK_W'(1);
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_ARM;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign randomnumber = rnum_q;
    assign timerdone    = timerdone_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign round_active = active_q;
    assign game_over    = over_q;

endmodule

// File: doc/round_master.md
# round_master

Round sequencer for the reaction game: picks a one-hot target button, runs the per-round response window, and consumes the registered `correct` verdict from the button checker. It drives the checker's `randomnumber` and `timerdone` inputs and sits between the start/score UI and the checker. It keeps score and lives, and shortens the response window after every hit.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clock cycles per window tick.
- `ROUND_TICKS`, 20: initial response window in ticks.
- `MIN_TICKS`, 4: floor for the shrinking window.
- `GAP_CYCLES`, 25_000_000: blank interval between rounds, in cycles.
- `LIVES`, 3: misses allowed before game over.
- `SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clock` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: level; any high cycle in IDLE or OVER starts a game.
- `correct` in 1: checker verdict, registered one cycle after its inputs.
- `randomnumber` out 4: one-hot target; 0 outside PLAY.
- `timerdone` out 1: high in every state except PLAY; forces checker `correct` low.
- `score` out 8: hits this game, saturating at 255.
- `lives` out 2: remaining lives.
- `round_active` out 1: high in PLAY.
- `game_over` out 1: high in OVER.

## Operation
- **States:** IDLE, ARM, PLAY, GAP, OVER.
- **Reset values:** IDLE; `randomnumber`=0; `timerdone`=1; `score`=0; `lives`=LIVES; `round_active`=0; `game_over`=0; LFSR=SEED; window=ROUND_TICKS.
- **IDLE/OVER + start:** clear `score`, reload `lives`=LIVES and window=ROUND_TICKS, go to ARM. In OVER, `score` holds until start.
- **ARM (1 cycle):**
  - Candidate = 4'b0001 << lfsr[1:0].
  - If the candidate equals the previous target, rotate it left by 1, so two consecutive targets never match.
  - Load the target, clear the prescaler and tick counter, go to PLAY.
- **PLAY:** `randomnumber`=target, `timerdone`=0, `correct` sampled every cycle.
  - `correct`=1: score+1 (saturating), window = max(window-1, MIN_TICKS), go to GAP.
  - Tick count reaches window with `correct`=0: lives-1; go to OVER if the result is 0, else GAP.
  - `correct`=1 on the expiry cycle: counts as a hit; the hit has priority.
- **GAP:** `randomnumber`=0, `timerdone`=1 for GAP_CYCLES cycles, then go to ARM.
- **LFSR:** 8-bit Galois LFSR, taps x^8+x^6+x^5+x^4+1. It free-runs every cycle in all states, so start timing randomizes the sequence, and it never reaches 0.
- **start outside IDLE/OVER:** ignored.

## Timing
- `randomnumber`, `timerdone` and `round_active` are registered; they change on the ARM→PLAY edge.
- `correct` is guaranteed 0 during the first PLAY cycle, because the checker sampled `timerdone`=1 at the previous edge. No separate blanking is needed.
- **Hit latency:** the button matches in PLAY cycle N, `correct` rises at edge N+1, and the state is GAP after edge N+2. `score` updates on the same edge.
- **Window length:** exactly window × TICK_DIV cycles from PLAY entry to the miss transition.
- **Held button:** a button held through GAP cannot hit the next round, because the next target always differs.
- **Reset mid-round:** asynchronous return to the reset values; no partial score is retained.

## Structure
- **Package `game_pkg`:**
  - State enum.
  - Target width (4).
  - Score width (8).
  - LFSR polynomial constant.
- **Sub-module `lfsr8`:** inputs `clock`, `resetn`, seed parameter; output `q[7:0]`.
- **Everything else in `round_master`:**
  - FSM.
  - Prescaler: $clog2(TICK_DIV) bits.
  - Tick counter: $clog2(ROUND_TICKS+1) bits.
  - GAP counter.
  - Score and lives registers.
  - Previous-target register.

## Test plan
Simulation parameters: TICK_DIV=4, ROUND_TICKS=8, MIN_TICKS=2, GAP_CYCLES=3, LIVES=3, with a behavioural checker model in the loop.
- **Reset during PLAY** (resetn low mid-round) -> all outputs take their reset values in the same cycle; `randomnumber`=0, `timerdone`=1.
- **Hit** (start, then drive button = target on PLAY cycle 2) -> `correct` high one cycle later; `score` goes 0→1; window goes 8→7; GAP lasts 3 cycles; then a new target that differs from the old one.
- **Miss** (never press) -> PLAY lasts exactly 32 cycles; `lives` goes 3→2; then GAP→ARM. After 3 misses: OVER, `game_over`=1, `score` held.
- **Window floor** (7 consecutive hits) -> window reaches 2 and stays at 2 on further hits.
- **Hit on expiry** (`correct` rises on the expiry cycle) -> counted as a hit; `lives` unchanged.
- **Start handling and saturation:**
  - `start` pulsed during PLAY -> ignored.
  - 256 hits -> `score` stays at 255.
